// File: rtl/irq_pkg.sv
// Shared types and constants for the external interrupt requester.
package irq_pkg;

  localparam int N_SRC_DEFAULT = 4;

  // ExcCode the decoder reports for an external interrupt.
  localparam logic [3:0] EXT_IRQ_ESTATUS = 4'b0001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; valid is high when any request is set.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    id    = '0;
    valid = |req;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// External interrupt requester for the core's ExtIRQ / ExtlAck handshake.
// Rising edges on irq_src become pending bits; the lowest unmasked pending
// source is requested and held until acknowledged, then further requests
// are blocked until the handler retires with ERET.
// Build option: IRQ_SYNC_EN adds a 2-flop synchronizer on each irq_src bit.
//
// state   | meaning
// IDLE    | no request outstanding, waiting for an unmasked pending source
// REQ     | ExtIRQ raised, irq_id frozen, waiting for ExtlAck
// SERVICE | handler running, irq_id held, waiting for ERet
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             ExtlAck,
  input  logic             ERet,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] irq_pending,
  output logic [N_SRC-1:0] irq_overrun,
  output logic             busy
);

  irq_state_t       state;
  logic [N_SRC-1:0] src_in;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync_1;
  logic [N_SRC-1:0] sync_2;

  // Two-stage synchronizer for asynchronous interrupt lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= irq_src;
      sync_2 <= sync_1;
    end
  end

  assign src_in = sync_2;
`else
  assign src_in = irq_src;
`endif

  // Edge-history register for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) src_q <= '0;
    else        src_q <= src_in;
  end

  assign rise = src_in & ~src_q;
  assign cand = irq_pending & ~irq_mask;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (cand),
    .id    (win_id),
    .valid (win_valid)
  );

  // One-hot clear of the acknowledged source.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = (state == REQ) && ExtlAck && (irq_id == ID_W'(i));
    end
  end

  // Pending and overrun bits; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending <= '0;
      irq_overrun <= '0;
    end else begin
      irq_pending <= (irq_pending & ~clr) | rise;
      irq_overrun <= (irq_overrun & ~clr) | (rise & irq_pending & ~clr);
    end
  end

  // Request / service sequencing; irq_id is only loaded when leaving IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            irq_id <= win_id;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ExtlAck) state <= SERVICE;
        end
        SERVICE: begin
          if (ERet) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ExtIRQ = (state == REQ);
  assign busy   = (state != IDLE);

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- External interrupt requester on the far side of the core's ExtIRQ / ExtlAck exception handshake.
- Collects rising edges on N_SRC interrupt lines into pending bits and applies a per-source mask.
- Selects the lowest-index unmasked pending source, raises ExtIRQ, and holds it with a stable ID until the core acknowledges.
- After the acknowledge, blocks further requests until the handler retires with ERET.

Parameters:
- N_SRC, 4, number of interrupt source lines (2..16).
- ID_W, $clog2(N_SRC), width of the source ID.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- irq_src  in  N_SRC  raw interrupt lines; a rising edge requests service.
- irq_mask  in  N_SRC  1 = source disabled for selection; its pending bit is still recorded.
- ExtlAck  in  1  acknowledge from the decoder (ExcAck && ExtIRQ).
- ERet  in  1  ERET executing; marks the end of the handler.
- ExtIRQ  out  1  interrupt request to the core.
- irq_id  out  ID_W  ID of the requested source; valid while ExtIRQ=1 and in SERVICE.
- irq_pending  out  N_SRC  current pending bits.
- irq_overrun  out  N_SRC  sticky: an edge arrived while that source was already pending.
- busy  out  1  1 in REQ or SERVICE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; ExtIRQ=0, irq_id=0, irq_pending=0, irq_overrun=0, busy=0, edge-history register=0.
- Edge detect: rise = irq_src & ~src_q, where src_q is irq_src registered every clk. A rise sets the pending bit at that clock edge.
- Set vs clear on the same edge for the same bit: set wins (the pending bit stays 1).
- Overrun: a rise on a bit whose pending bit is already 1 and is not being cleared that cycle sets irq_overrun[i]. irq_overrun[i] clears when source i is acknowledged.
- Selection: cand = irq_pending & ~irq_mask. The winner is the lowest set index (priority encoder).
- FSM, states IDLE, REQ, SERVICE:
  - IDLE: if cand≠0, latch the winner into irq_id and go to REQ on the next edge; else stay.
  - REQ: ExtIRQ=1, busy=1. irq_id is frozen; it does not change if a higher-priority source arrives or the mask changes.
  - REQ, ExtlAck=1: clear irq_pending[irq_id] and irq_overrun[irq_id], go to SERVICE.
  - SERVICE: ExtIRQ=0, busy=1, irq_id held. ERet=1 → IDLE.
- Latency: the source is high at clock edge k (low at k-1) → pending set at k → REQ entered and ExtIRQ high from k+1.
- After ERet, the next request (if cand≠0) has ExtIRQ high 2 edges later: IDLE for one cycle.
- Ignored inputs: ExtlAck in IDLE or SERVICE; ERet in IDLE or REQ.
- Masking a source already latched in REQ does not withdraw the request.
- Level-held sources do not re-trigger; a new request needs a new rising edge.
- Reset asserted mid-REQ or mid-SERVICE: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irq_src passes through a 2-flop synchronizer per bit before edge detection. The latency in Behaviour grows by 2 cycles (ExtIRQ high from k+3). The synchronizer flops reset to 0.
- Undefined: irq_src is used directly; sources must be synchronous to clk.

Decomposition:
- Package irq_pkg:
  - irq_state_t enum {IDLE, REQ, SERVICE}.
  - Default N_SRC constant.
  - EXT_IRQ_ESTATUS = 4'b0001 (shared with the decoder).
- Sub-module irq_prio_enc: combinational N_SRC→ID_W lowest-index encoder with a valid output. It is instantiated once.

Test Plan:
1. Reset deassert, pulse irq_src[2] for 1 cycle → pending=0100 at k, ExtIRQ=1 and irq_id=2 from k+1. ExtlAck → pending=0000, SERVICE. ERet → IDLE, busy=0.
2. Rise on src[3] and src[1] on the same edge → irq_id=1 served first. After ERet, ExtIRQ reasserts with irq_id=3.
3. irq_mask=0010, rise on src[1] → pending[1]=1, ExtIRQ stays 0. Clear the mask → request with irq_id=1 next cycle.
4. src[0] edge while pending[0]=1 → irq_overrun=0001; the ack of src 0 clears it to 0000.
5. In REQ with irq_id=2, a src[0] edge arrives → irq_id stays 2. Drop reset mid-SERVICE → all outputs 0 and state IDLE immediately.
6. ExtlAck pulsed in IDLE and ERet pulsed in REQ → no state change. With IRQ_SYNC_EN defined, test 1 shows ExtIRQ high from k+3.
